// File: rtl/dot_product_array.sv
// Parallel-lane vector multiply/accumulate over on-chip A, B, C memories
// with a global dot-product reduction of every lane product.
module dot_product_array #(
  parameter int Addr_Width     = 4,
  parameter int Para_Deg       = 2,
  parameter int Data_Width_In  = 8,
  parameter int Data_Width_Out = 16,
  parameter int Sum_Width      = 24,
  parameter bit Saturate       = 1'b1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                wr_en,
  input  logic [Addr_Width-1:0]               wr_addr,
  input  logic [Para_Deg*Data_Width_In-1:0]   wr_a,
  input  logic [Para_Deg*Data_Width_In-1:0]   wr_b,
  input  logic [Para_Deg*Data_Width_Out-1:0]  wr_c,
  input  logic [Addr_Width-1:0]               rd_addr,
  output logic [Para_Deg*Data_Width_Out-1:0]  rd_data,
  input  logic                                start,
  input  logic [Addr_Width:0]                 length,
  input  logic                                accumulate,
  output logic                                busy,
  output logic                                done,
  output logic [Sum_Width-1:0]                dot_sum
);

  localparam int Depth = 1 << Addr_Width;
  localparam int PW    = 2 * Data_Width_In;
  localparam int AW    = Data_Width_In * Para_Deg;
  localparam int CW    = Data_Width_Out * Para_Deg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nx;

  logic [AW-1:0] mem_a [Depth];
  logic [AW-1:0] mem_b [Depth];
  logic [CW-1:0] mem_c [Depth];

  logic [Addr_Width:0]   len_cl, len_q, cnt;
  logic [1:0]            drain_cnt;
  logic                  acc_q;
  logic                  go, issue, host_wr;
  logic [Addr_Width-1:0] issue_addr;

  logic                  s1_v, s2_v;
  logic [Addr_Width-1:0] s1_addr, s2_addr;
  logic [AW-1:0]         s1_a, s1_b;
  logic [CW-1:0]         s1_c, s2_c;
  logic [Para_Deg*PW-1:0] prod_w, s2_prod;
  logic [CW-1:0]         new_c;
  logic [Data_Width_Out:0] sum_w;
  logic [Sum_Width-1:0]  prod_total;

  assign len_cl = (length > (Addr_Width+1)'(Depth)) ?
                  (Addr_Width+1)'(Depth) : length;
  assign go         = (state == IDLE) && start;
  assign issue      = (state == RUN);
  assign host_wr    = wr_en && (state == IDLE);
  assign issue_addr = cnt[Addr_Width-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = (len_cl != '0) ? RUN : DONE;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == len_q - 1'b1) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == 2'd2) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q     <= '0;
      cnt       <= '0;
      drain_cnt <= '0;
      acc_q     <= 1'b0;
    end else if (go) begin
      len_q     <= len_cl;
      cnt       <= '0;
      drain_cnt <= '0;
      acc_q     <= accumulate;
    end else begin
      if (issue)            cnt       <= cnt + 1'b1;
      if (state == DRAIN)   drain_cnt <= drain_cnt + 1'b1;
    end
  end

  // Only the valids reset, so a reset drops every in-flight C write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1_v <= issue;
      s2_v <= s1_v;
    end
  end

  always_ff @(posedge clk) begin
    s1_addr <= issue_addr;
    s1_a    <= mem_a[issue_addr];
    s1_b    <= mem_b[issue_addr];
    s1_c    <= mem_c[issue_addr];
    s2_addr <= s1_addr;
    s2_prod <= prod_w;
    s2_c    <= acc_q ? s1_c : '0;
  end

  always_comb begin
    prod_w     = '0;
    new_c      = '0;
    sum_w      = '0;
    prod_total = '0;
    for (int k = 0; k < Para_Deg; k++) begin
      prod_w[k*PW +: PW] = s1_a[k*Data_Width_In +: Data_Width_In] *
                           s1_b[k*Data_Width_In +: Data_Width_In];
      sum_w = {1'b0, s2_c[k*Data_Width_Out +: Data_Width_Out]} +
              (Data_Width_Out+1)'(s2_prod[k*PW +: PW]);
      if (Saturate && sum_w[Data_Width_Out])
        new_c[k*Data_Width_Out +: Data_Width_Out] = '1;
      else
        new_c[k*Data_Width_Out +: Data_Width_Out] = sum_w[Data_Width_Out-1:0];
      prod_total = prod_total + Sum_Width'(s2_prod[k*PW +: PW]);
    end
  end

  // Host writes happen only in IDLE, pipeline writes only while busy.
  always_ff @(posedge clk) begin
    if (host_wr) begin
      mem_a[wr_addr] <= wr_a;
      mem_b[wr_addr] <= wr_b;
      mem_c[wr_addr] <= wr_c;
    end else if (s2_v) begin
      mem_c[s2_addr] <= new_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     dot_sum <= '0;
    else if (go)   dot_sum <= '0;
    else if (s2_v) dot_sum <= dot_sum + prod_total;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem_c[rd_addr];
  end

endmodule

// File: tb/tb_dot_product_array.sv
// Scoreboard bench for dot_product_array: randomized and directed passes
// checked against an arithmetic reference of the vector memories.
module tb_dot_product_array;

  localparam int AW  = 4;
  localparam int PD  = 2;
  localparam int DWI = 8;
  localparam int DWO = 16;
  localparam int SW  = 24;
  localparam int SAT = 1;
  localparam int D   = 1 << AW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [PD*DWI-1:0] wr_a = '0;
  logic [PD*DWI-1:0] wr_b = '0;
  logic [PD*DWO-1:0] wr_c = '0;
  logic [AW-1:0]     rd_addr = '0;
  logic [PD*DWO-1:0] rd_data;
  logic              start = 1'b0;
  logic [AW:0]       length = '0;
  logic              accumulate = 1'b0;
  logic              busy, done;
  logic [SW-1:0]     dot_sum;

  always #5 clk = ~clk;

  dot_product_array dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_a(wr_a), .wr_b(wr_b), .wr_c(wr_c), .rd_addr(rd_addr),
    .rd_data(rd_data), .start(start), .length(length),
    .accumulate(accumulate), .busy(busy), .done(done), .dot_sum(dot_sum)
  );

  int total = 0;
  int bad = 0;

  int unsigned ma [D][PD];
  int unsigned mb [D][PD];
  int unsigned mc [D][PD];

  logic [SW-1:0]     sum_q[$];
  logic [PD*DWO-1:0] rd_q[$];
  logic              rd_req = 1'b0;
  logic              rd_pend = 1'b0;

  always @(posedge clk) rd_pend <= rd_req;

  task automatic check(string nm, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sum_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done got=1 want=0");
      end else check("dot_sum", dot_sum, sum_q.pop_front());
    end
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected got=%0d want=none", rd_data);
      end else check("rd_data", rd_data, rd_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_wr(int ad, int unsigned a0, int unsigned a1,
                        int unsigned b0, int unsigned b1,
                        int unsigned c0, int unsigned c1);
    wr_en = 1'b1;
    wr_addr = AW'(ad);
    wr_a = {8'(a1), 8'(a0)};
    wr_b = {8'(b1), 8'(b0)};
    wr_c = {16'(c1), 16'(c0)};
    ma[ad][0] = a0 & 255; ma[ad][1] = a1 & 255;
    mb[ad][0] = b0 & 255; mb[ad][1] = b1 & 255;
    mc[ad][0] = c0 & 65535; mc[ad][1] = c1 & 65535;
  endtask

  task automatic load(int ad, int unsigned a0, int unsigned a1,
                      int unsigned b0, int unsigned b1,
                      int unsigned c0, int unsigned c1);
    set_wr(ad, a0, a1, b0, b1, c0, c1);
    tick();
    wr_en = 1'b0;
  endtask

  function automatic void model_pass(int len, bit acc);
    int n;
    longint s, p, t;
    n = (len > D) ? D : len;
    s = 0;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < PD; k++) begin
        p = longint'(ma[i][k]) * longint'(mb[i][k]);
        t = (acc ? longint'(mc[i][k]) : 0) + p;
        if (t > 65535) t = SAT ? 65535 : t - 65536;
        mc[i][k] = int'(t);
        s += p;
      end
    sum_q.push_back(SW'(s % (longint'(1) << SW)));
  endfunction

  task automatic run_pass(int len, bit acc, bit disturb);
    int n, bc, ex, l;
    l = (len > D) ? D : len;
    ex = (l > 0) ? l + 3 : 0;
    model_pass(len, acc);
    start = 1'b1;
    length = 5'(len);
    accumulate = acc;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    n = 0;
    bc = 0;
    while (!done && n < 100) begin
      if (busy) bc++;
      if (disturb && n == 2) begin
        start = 1'b1; length = 5'd3; wr_en = 1'b1; wr_addr = '0;
        wr_a = '1; wr_b = '1; wr_c = '1;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    wr_en = 1'b0;
    check("latency", n, ex);
    check("busy_cycles", bc, ex);
    tick();
    check("done_width", done, 0);
  endtask

  task automatic read_all();
    for (int i = 0; i < D; i++) begin
      rd_addr = AW'(i);
      rd_q.push_back({16'(mc[i][1]), 16'(mc[i][0])});
      rd_req = 1'b1;
      tick();
    end
    rd_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic load_ramp(int unsigned cval);
    for (int i = 0; i < D; i++)
      load(i, i + 1, i + 1, 2, 2, cval, cval);
  endtask

  initial begin
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", dot_sum, 0);
    check("rst_rd", rd_data, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    load_ramp(0);
    run_pass(16, 0, 0);
    read_all();

    load_ramp(100);
    run_pass(16, 1, 0);
    read_all();

    load(0, 255, 255, 255, 255, 65000, 65000);
    run_pass(1, 1, 0);
    read_all();

    load_ramp(0);
    run_pass(5, 0, 0);
    read_all();
    run_pass(20, 1, 0);
    read_all();

    set_wr(3, 200, 17, 9, 250, 1234, 60000);
    run_pass(16, 1, 0);
    read_all();

    run_pass(16, 0, 1);
    read_all();
    run_pass(0, 0, 0);
    read_all();

    start = 1'b1; length = 5'd16; accumulate = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_sum", dot_sum, 0);
    check("mid_rst_rd", rd_data, 0);
    tick(); tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    load_ramp(7);
    run_pass(16, 1, 0);
    read_all();

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < D; i++)
        load(i, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      run_pass(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), 0);
      read_all();
    end

    tick(); tick();
    check("sum_q_left", sum_q.size(), 0);
    check("rd_q_left", rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
